sr_cmd_driver: RTL and testbench

Command-side driver for the board's SR latch. Takes two raw, bouncy pushbutton inputs (set, reset), synchronizes and debounces them, and converts each press into an `{s,r}` command held stable for exactly one slow-tick period, so the latch always samples a settled pattern. It also generates the slow tick from the fabric system clock. It sits between the board buttons and the latch's `s`/`r` inputs.

---
 rtl/sr_cmd_driver.sv | 264 ++++++++++++++++++++++++++
 tb/tb_sr_cmd_driver.sv | 246 ++++++++++++++++++++++++
 2 files changed

// File: rtl/sr_cmd_driver.sv
// ---------------------------------------------------------------------------
// sr_cmd_driver
//
// Command-side driver for the board SR latch. Two raw pushbuttons (set,
// reset) are synchronized, optionally debounced and edge-detected. Each press
// becomes an {s,r} command that is held for exactly one slow-tick period, so
// the latch only ever samples a settled pattern. The slow tick is derived
// from clk.
//
// Command encoding (latch convention):
//   SET   : s=0 r=1
//   RESET : s=1 r=0
//   HOLD  : s=1 r=1   ({s,r}=00 is never driven)
//
// Build option:
//   SR_CMD_DEBOUNCE_EN  defined   -> per-button debounce counters present
//                       undefined -> synchronized level used directly,
//                                    DEBOUNCE_CYCLES ignored
//
// Parameters:
//   DEBOUNCE_CYCLES  consecutive stable cycles before a debounced level
//                    changes (>= 2)
//   TICK_DIV         slow-tick period in clk cycles (>= 2)
//
// Ports:
//   clk          system clock (only clock)
//   rst_n        synchronous active-low reset
//   btn_set_raw  raw set button, asynchronous, active-high
//   btn_rst_raw  raw reset button, asynchronous, active-high
//   s, r         registered latch command outputs
//   tick         one-clk pulse per slow-tick period
//   busy         high whenever the FSM is not IDLE
//
// state  | meaning
// -------+--------------------------------------------------------------
// IDLE   | outputs at HOLD, waiting for a pending command
// ARMED  | command pending, waiting for the next tick to start driving it
// DRIVE  | {s,r} held for one tick period; chains a pending command or
//        | returns to HOLD on the next tick
// ---------------------------------------------------------------------------
module sr_cmd_driver #(
    parameter int DEBOUNCE_CYCLES = 1000000,
    parameter int TICK_DIV        = 30000000
) (
    input  logic clk,
    input  logic rst_n,
    input  logic btn_set_raw,
    input  logic btn_rst_raw,
    output logic s,
    output logic r,
    output logic tick,
    output logic busy
);

    if (DEBOUNCE_CYCLES < 2) begin : g_bad_debounce
        $error("sr_cmd_driver: DEBOUNCE_CYCLES must be at least 2");
    end
    if (TICK_DIV < 2) begin : g_bad_tick
        $error("sr_cmd_driver: TICK_DIV must be at least 2");
    end

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ARMED = 2'd1,
        ST_DRIVE = 2'd2
    } state_t;

    localparam int              TW        = $clog2(TICK_DIV);
    localparam logic [TW-1:0]   TICK_LAST = TW'(TICK_DIV - 1);

    // Bit 0 carries the set button, bit 1 the reset button throughout.
    logic [1:0] sync1_q, sync1_d;
    logic [1:0] sync2_q, sync2_d;
    logic [1:0] deb_lvl;
    logic [1:0] deb_prev_q, deb_prev_d;
    logic [1:0] press;

    logic [TW-1:0] tick_cnt_q, tick_cnt_d;
    logic          tick_q, tick_d;

    logic   pend_valid_q, pend_valid_d;
    logic   pend_rst_q, pend_rst_d;
    logic   load;

    state_t state_q, state_d;
    logic   s_q, s_d;
    logic   r_q, r_d;
    logic   busy_q, busy_d;

    // -----------------------------------------------------------------------
    // Two-flop synchronizer
    // -----------------------------------------------------------------------
    always_comb begin
        sync1_d = {btn_rst_raw, btn_set_raw};
        sync2_d = sync1_q;
    end

    // -----------------------------------------------------------------------
    // Debounce (optional)
    // -----------------------------------------------------------------------
`ifdef SR_CMD_DEBOUNCE_EN
    localparam int            DW       = $clog2(DEBOUNCE_CYCLES);
    localparam logic [DW-1:0] DEB_LAST = DW'(DEBOUNCE_CYCLES - 1);

    logic [1:0]         deb_q, deb_d;
    logic [1:0][DW-1:0] deb_cnt_q, deb_cnt_d;

    // The counter value DEB_LAST marks the DEBOUNCE_CYCLES-th differing
    // cycle, so the level flips on that edge and the counter restarts.
    always_comb begin
        deb_d     = deb_q;
        deb_cnt_d = deb_cnt_q;
        for (int i = 0; i < 2; i++) begin
            if (sync2_q[i] == deb_q[i]) begin
                deb_cnt_d[i] = '0;
            end else if (deb_cnt_q[i] == DEB_LAST) begin
                deb_d[i]     = sync2_q[i];
                deb_cnt_d[i] = '0;
            end else begin
                deb_cnt_d[i] = deb_cnt_q[i] + DW'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            deb_q     <= '0;
            deb_cnt_q <= '0;
        end else begin
            deb_q     <= deb_d;
            deb_cnt_q <= deb_cnt_d;
        end
    end

    assign deb_lvl = deb_q;
`else
    assign deb_lvl = sync2_q;
`endif

    // -----------------------------------------------------------------------
    // Rising-edge detect on the debounced levels; releases produce nothing.
    // -----------------------------------------------------------------------
    always_comb begin
        deb_prev_d = deb_lvl;
        press      = deb_lvl & ~deb_prev_q;
    end

    // -----------------------------------------------------------------------
    // Slow tick: count 0..TICK_DIV-1; tick is registered so it is high while
    // the count register holds TICK_DIV-1.
    // -----------------------------------------------------------------------
    always_comb begin
        if (tick_cnt_q == TICK_LAST) begin
            tick_cnt_d = '0;
        end else begin
            tick_cnt_d = tick_cnt_q + TW'(1);
        end
        tick_d = (tick_cnt_d == TICK_LAST);
    end

    // -----------------------------------------------------------------------
    // Pending command. A press in the same cycle as a load overrides the
    // clear, so it becomes the next command instead of being dropped.
    // -----------------------------------------------------------------------
    always_comb begin
        pend_valid_d = pend_valid_q;
        pend_rst_d   = pend_rst_q;
        if (load) begin
            pend_valid_d = 1'b0;
        end
        if (press[1]) begin
            pend_valid_d = 1'b1;
            pend_rst_d   = 1'b1;
        end else if (press[0]) begin
            pend_valid_d = 1'b1;
            pend_rst_d   = 1'b0;
        end
    end

    // -----------------------------------------------------------------------
    // FSM next-state and output logic
    // -----------------------------------------------------------------------
    always_comb begin
        state_d = state_q;
        s_d     = s_q;
        r_d     = r_q;
        load    = 1'b0;

        unique case (state_q)
            ST_IDLE: begin
                s_d = 1'b1;
                r_d = 1'b1;
                if (pend_valid_q) begin
                    state_d = ST_ARMED;
                end
            end
            ST_ARMED: begin
                if (tick_q) begin
                    load    = 1'b1;
                    s_d     = pend_rst_q;
                    r_d     = ~pend_rst_q;
                    state_d = ST_DRIVE;
                end
            end
            ST_DRIVE: begin
                if (tick_q) begin
                    if (pend_valid_q) begin
                        load = 1'b1;
                        s_d  = pend_rst_q;
                        r_d  = ~pend_rst_q;
                    end else begin
                        s_d     = 1'b1;
                        r_d     = 1'b1;
                        state_d = ST_IDLE;
                    end
                end
            end
            default: begin
                s_d     = 1'b1;
                r_d     = 1'b1;
                state_d = ST_IDLE;
            end
        endcase

        busy_d = (state_d != ST_IDLE);
    end

    // -----------------------------------------------------------------------
    // State registers
    // -----------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            sync1_q      <= '0;
            sync2_q      <= '0;
            deb_prev_q   <= '0;
            tick_cnt_q   <= '0;
            tick_q       <= 1'b0;
            pend_valid_q <= 1'b0;
            pend_rst_q   <= 1'b0;
            state_q      <= ST_IDLE;
            s_q          <= 1'b1;
            r_q          <= 1'b1;
            busy_q       <= 1'b0;
        end else begin
            sync1_q      <= sync1_d;
            sync2_q      <= sync2_d;
            deb_prev_q   <= deb_prev_d;
            tick_cnt_q   <= tick_cnt_d;
            tick_q       <= tick_d;
            pend_valid_q <= pend_valid_d;
            pend_rst_q   <= pend_rst_d;
            state_q      <= state_d;
            s_q          <= s_d;
            r_q          <= r_d;
            busy_q       <= busy_d;
        end
    end

    assign s    = s_q;
    assign r    = r_q;
    assign tick = tick_q;
    assign busy = busy_q;

endmodule

// File: tb/tb_sr_cmd_driver.sv
// ---------------------------------------------------------------------------
// tb_sr_cmd_driver
//
// Directed bench for sr_cmd_driver with DEBOUNCE_CYCLES=4, TICK_DIV=8.
// Inputs are driven and outputs sampled on the falling edge of clk.
// Expected latencies depend on whether SR_CMD_DEBOUNCE_EN is defined:
//   press-to-pending: 2 sync + 4 debounce + 1 edge = 7 cycles (else 3)
//   busy rises one cycle after pending.
// ---------------------------------------------------------------------------
module tb_sr_cmd_driver;

    localparam int DEB  = 4;
    localparam int TDIV = 8;
`ifdef SR_CMD_DEBOUNCE_EN
    localparam int PRESS_LAT = DEB + 3;
    localparam int RST_OFF   = 4;
`else
    localparam int PRESS_LAT = 3;
    localparam int RST_OFF   = 8;
`endif
    localparam int BUSY_LAT = PRESS_LAT + 1;

    logic clk         = 1'b0;
    logic rst_n       = 1'b0;
    logic btn_set_raw = 1'b0;
    logic btn_rst_raw = 1'b0;
    logic s, r, tick, busy;

    int vec_cnt = 0;
    int err_cnt = 0;

    sr_cmd_driver #(
        .DEBOUNCE_CYCLES(DEB),
        .TICK_DIV       (TDIV)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .btn_set_raw(btn_set_raw),
        .btn_rst_raw(btn_rst_raw),
        .s          (s),
        .r          (r),
        .tick       (tick),
        .busy       (busy)
    );

    always #5 clk = ~clk;

    task automatic chk_eq(input string tag, input int got, input int exp);
        vec_cnt++;
        if (got != exp) begin
            err_cnt++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Waits for a command to start, checks each of n back-to-back commands
    // (c0 then c1...) is held exactly TDIV cycles starting and ending on a
    // tick, then HOLD with busy low and no further activity.
    task automatic expect_cmds(input string tag, input logic [1:0] c0,
                               input logic [1:0] c1, input int n);
        int         waited;
        int         len;
        logic [1:0] exp_sr;
        logic       prev_tick;
        bit         extra;
        waited    = 0;
        prev_tick = 1'b0;
        @(negedge clk);
        while ({s, r} == 2'b11 && waited < 80) begin
            prev_tick = tick;
            @(negedge clk);
            waited++;
        end
        chk_eq({tag, "_start_seen"}, int'(waited < 80), 1);
        if (waited >= 80) return;
        chk_eq({tag, "_start_after_tick"}, int'(prev_tick), 1);
        chk_eq({tag, "_busy_high"}, int'(busy), 1);
        for (int i = 0; i < n; i++) begin
            exp_sr = (i == 0) ? c0 : c1;
            chk_eq({tag, "_sr"}, int'({s, r}), int'(exp_sr));
            len = 0;
            while ({s, r} == exp_sr && len < 40) begin
                prev_tick = tick;
                @(negedge clk);
                len++;
            end
            chk_eq({tag, "_len"}, len, TDIV);
            chk_eq({tag, "_end_on_tick"}, int'(prev_tick), 1);
        end
        chk_eq({tag, "_hold"}, int'({s, r}), 3);
        chk_eq({tag, "_busy_fall"}, int'(busy), 0);
        extra = 1'b0;
        repeat (24) begin
            @(negedge clk);
            if (busy || {s, r} != 2'b11) extra = 1'b1;
        end
        chk_eq({tag, "_no_extra"}, int'(extra), 0);
    endtask

    task automatic expect_quiet(input string tag, input int n);
        bit seen;
        seen = 1'b0;
        repeat (n) begin
            @(negedge clk);
            if (busy || {s, r} != 2'b11) seen = 1'b1;
        end
        chk_eq(tag, int'(seen), 0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        int k;

        // Reset with both buttons pressed
        rst_n       = 1'b0;
        btn_set_raw = 1'b1;
        btn_rst_raw = 1'b1;
        cyc(3);
        chk_eq("rst_s", int'(s), 1);
        chk_eq("rst_r", int'(r), 1);
        chk_eq("rst_tick", int'(tick), 0);
        chk_eq("rst_busy", int'(busy), 0);
        rst_n       = 1'b1;
        btn_set_raw = 1'b0;
        btn_rst_raw = 1'b0;

        n = 0;
        do begin cyc(1); n++; end while (!tick && n < 20);
        chk_eq("first_tick_lat", n, TDIV - 1);
        for (int p = 0; p < 2; p++) begin
            n = 0;
            do begin cyc(1); n++; end while (!tick && n < 20);
            chk_eq("tick_period", n, TDIV);
        end
        chk_eq("idle_after_reset", int'(busy), 0);

        // Clean set press
        fork
            begin
                btn_set_raw = 1'b1;
                cyc(20);
                btn_set_raw = 1'b0;
            end
            begin
                n = 0;
                do begin cyc(1); n++; end while (!busy && n < 40);
                chk_eq("set_busy_lat", n, BUSY_LAT);
            end
            expect_cmds("set", 2'b01, 2'b01, 1);
        join

`ifdef SR_CMD_DEBOUNCE_EN
        // Bouncing reset button yields one command
        fork
            begin
                for (int i = 0; i < 6; i++) begin
                    btn_rst_raw = (i % 2 == 0);
                    cyc(2);
                end
                btn_rst_raw = 1'b1;
                cyc(20);
                btn_rst_raw = 1'b0;
            end
            expect_cmds("bounce", 2'b10, 2'b10, 1);
        join

        // A one-cycle glitch is filtered out
        btn_set_raw = 1'b1;
        cyc(1);
        btn_set_raw = 1'b0;
        expect_quiet("short_press_filtered", 30);
`else
        // Without debounce a one-cycle press is a command
        fork
            begin
                btn_set_raw = 1'b1;
                cyc(1);
                btn_set_raw = 1'b0;
            end
            expect_cmds("short_press", 2'b01, 2'b01, 1);
        join
`endif

        // Simultaneous press: RESET wins
        fork
            begin
                btn_set_raw = 1'b1;
                btn_rst_raw = 1'b1;
                cyc(20);
                btn_set_raw = 1'b0;
                btn_rst_raw = 1'b0;
            end
            expect_cmds("simul", 2'b10, 2'b10, 1);
        join

        // Back-to-back: reset pressed as soon as the SET drive begins
        fork
            begin
                btn_set_raw = 1'b1;
                k = 0;
                do begin cyc(1); k++; end while ({s, r} != 2'b01 && k < 80);
                btn_set_raw = 1'b0;
                btn_rst_raw = 1'b1;
                cyc(12);
                btn_rst_raw = 1'b0;
            end
            expect_cmds("b2b", 2'b01, 2'b10, 2);
        join

        // Abort mid-DRIVE with a RESET pending; phase-locked to the tick
        k = 0;
        do begin cyc(1); k++; end while (!tick && k < 20);
        chk_eq("abort_tick_found", int'(tick), 1);
        btn_set_raw = 1'b1;
        cyc(RST_OFF);
        btn_rst_raw = 1'b1;
        cyc(10 - RST_OFF);
        chk_eq("abort_drive_start", int'({s, r}), 1);
        chk_eq("abort_busy_drive", int'(busy), 1);
        cyc(3);
        chk_eq("abort_mid_drive", int'({s, r}), 1);
        rst_n       = 1'b0;
        btn_set_raw = 1'b0;
        btn_rst_raw = 1'b0;
        cyc(1);
        chk_eq("abort_sr", int'({s, r}), 3);
        chk_eq("abort_busy", int'(busy), 0);
        chk_eq("abort_tick", int'(tick), 0);
        rst_n = 1'b1;
        expect_quiet("abort_pending_dropped", 30);

        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
        $finish;
    end

endmodule
